// File: rtl/poli_gate_scheduler.sv
// Round-robin scheduler that time-shares one polymorphic NAND/NOR/XOR/BUF gate between two requesters.
// Optional macro POLI_SELFCHECK_EN adds a selfcheck_err output comparing the sampled X against the expected function.
module poli_gate_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned EVAL_CYCLES   = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_mode,
  input  logic       req0_a,
  input  logic       req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_mode,
  input  logic       req1_a,
  input  logic       req1_b,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [1:0] resp_mode,
  output logic       resp_x,
  output logic       poli_sel,
  output logic       poli_vxx,
  output logic       poli_vyy,
  output logic       poli_a,
  output logic       poli_b,
  input  logic       poli_x,
  output logic       busy
`ifdef POLI_SELFCHECK_EN
  ,
  output logic       selfcheck_err
`endif
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVAL_LOAD   = CNT_W'(EVAL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONFIG, EVAL, RESP} state_t;

  typedef struct packed {
    logic       id;
    logic [1:0] mode;
    logic       a;
    logic       b;
  } op_t;

  // Mode to gate pin map {sel, vxx, vyy}
  function automatic logic [2:0] mode_cfg(input logic [1:0] mode);
    logic [2:0] cfg;
    case (mode)
      2'b00:   cfg = 3'b011;
      2'b01:   cfg = 3'b000;
      2'b10:   cfg = 3'b110;
      default: cfg = 3'b101;
    endcase
    return cfg;
  endfunction

`ifdef POLI_SELFCHECK_EN
  function automatic logic expect_x(input op_t op);
    logic x;
    case (op.mode)
      2'b00:   x = ~(op.a & op.b);
      2'b01:   x = ~(op.a | op.b);
      2'b10:   x = op.a ^ op.b;
      default: x = op.a;
    endcase
    return x;
  endfunction

  logic err_q, err_d;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t              op_q, op_d;
  logic [1:0]       cur_mode_q, cur_mode_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic             last_q, last_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [1:0]       resp_mode_q, resp_mode_d;
  logic             resp_x_q, resp_x_d;
  logic [2:0]       cfg_q, cfg_d;
  logic [1:0]       opnd_q, opnd_d;
  logic             busy_q, busy_d;
  logic [1:0]       grant;

  // Next-state, datapath and handshake logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    cur_mode_d   = cur_mode_q;
    cfg_valid_d  = cfg_valid_q;
    last_d       = last_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_mode_d  = resp_mode_q;
    resp_x_d     = resp_x_q;
    cfg_d        = cfg_q;
    opnd_d       = opnd_q;
`ifdef POLI_SELFCHECK_EN
    err_d        = 1'b0;
`endif
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    // Alternate only under contention; last_q names the previous winner
    if (req0_valid && req1_valid) begin
      grant = last_q ? 2'b01 : 2'b10;
    end else begin
      grant = {req1_valid, req0_valid};
    end

    unique case (state_q)
      IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        if (grant != 2'b00) begin
          if (grant[1]) begin
            op_d = {1'b1, req1_mode, req1_a, req1_b};
          end else begin
            op_d = {1'b0, req0_mode, req0_a, req0_b};
          end
          last_d = grant[1];
          if (!cfg_valid_q || (op_d.mode != cur_mode_q)) begin
            state_d    = CONFIG;
            cnt_d      = SETTLE_LOAD;
            cfg_d      = mode_cfg(op_d.mode);
            cur_mode_d = op_d.mode;
          end else begin
            state_d = EVAL;
            cnt_d   = EVAL_LOAD;
            opnd_d  = {op_d.a, op_d.b};
          end
        end
      end
      CONFIG: begin
        if (cnt_q == '0) begin
          cfg_valid_d = 1'b1;
          state_d     = EVAL;
          cnt_d       = EVAL_LOAD;
          opnd_d      = {op_q.a, op_q.b};
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      EVAL: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_id_d    = op_q.id;
          resp_mode_d  = op_q.mode;
          resp_x_d     = poli_x;
`ifdef POLI_SELFCHECK_EN
          err_d        = (poli_x != expect_x(op_q));
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      cur_mode_q   <= 2'b00;
      cfg_valid_q  <= 1'b0;
      last_q       <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_mode_q  <= 2'b00;
      resp_x_q     <= 1'b0;
      cfg_q        <= 3'b000;
      opnd_q       <= 2'b00;
      busy_q       <= 1'b0;
`ifdef POLI_SELFCHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      cur_mode_q   <= cur_mode_d;
      cfg_valid_q  <= cfg_valid_d;
      last_q       <= last_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_mode_q  <= resp_mode_d;
      resp_x_q     <= resp_x_d;
      cfg_q        <= cfg_d;
      opnd_q       <= opnd_d;
      busy_q       <= busy_d;
`ifdef POLI_SELFCHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_mode  = resp_mode_q;
  assign resp_x     = resp_x_q;
  assign poli_sel   = cfg_q[2];
  assign poli_vxx   = cfg_q[1];
  assign poli_vyy   = cfg_q[0];
  assign poli_a     = opnd_q[1];
  assign poli_b     = opnd_q[0];
  assign busy       = busy_q;
`ifdef POLI_SELFCHECK_EN
  assign selfcheck_err = err_q;
`endif

endmodule
